// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: wakes a shared gated clock on request or activity,
// grants requesters once the clock has settled, and gates it off after an idle hysteresis.
module clk_gate_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               busy_i,
    output logic [NUM_REQ-1:0] ack_o,
    output logic               gate_en_o,
    output logic [1:0]         state_o,
    output logic [15:0]        wake_cnt_o
);

    localparam int MAX_CYC = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      wake_cnt_q;
    logic             activity;

    assign activity = (|req_i) | busy_i;

    // NOTE: every register, including the gate enable, is cleared asynchronously so the
    // clock gate closes the instant arst_i rises; state uses non-blocking updates only.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            gate_en_o  <= 1'b0;
            wake_cnt_q <= '0;
        end else begin
            case (state_q)
                OFF: begin
                    if (activity) begin
                        state_q   <= WAKE;
                        cnt_q     <= WAKE_LOAD;
                        gate_en_o <= 1'b1;
                        if (wake_cnt_q != 16'hFFFF)
                            wake_cnt_q <= wake_cnt_q + 16'd1;
                    end
                end
                // WAKE always runs to completion so the gate sampler sees a settled enable.
                WAKE: begin
                    if (cnt_q == '0)
                        state_q <= ON;
                    else
                        cnt_q <= cnt_q - 1'b1;
                end
                ON: begin
                    if (!activity) begin
                        state_q <= DRAIN;
                        cnt_q   <= IDLE_LOAD;
                    end
                end
                DRAIN: begin
                    if (activity) begin
                        state_q <= ON;
                    end else if (cnt_q == '0) begin
                        state_q   <= OFF;
                        gate_en_o <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= OFF;
            endcase
        end
    end

    // All requesters share one clock, so every requesting bit is granted together.
    assign ack_o      = {NUM_REQ{state_q == ON}} & req_i;
    assign state_o    = state_q;
    assign wake_cnt_o = wake_cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus randomized bursts
// compared against a model built from enable age and idle-run length.
module tb_clk_gate_ctrl;

    localparam int NR = 4;
    localparam int WK = 2;
    localparam int ID = 16;

    logic          clk_i = 1'b0;
    logic          arst_i;
    logic [NR-1:0] req_i;
    logic          busy_i;
    logic [NR-1:0] ack_o;
    logic          gate_en_o;
    logic [1:0]    state_o;
    logic [15:0]   wake_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model: gate on/off, cycles since enable, consecutive idle cycles once running.
    bit m_en;
    int m_age;
    int m_idle;
    int m_wake;

    always #5 clk_i = ~clk_i;

    clk_gate_ctrl #(
        .NUM_REQ    (NR),
        .WAKE_CYCLES(WK),
        .IDLE_CYCLES(ID)
    ) dut (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .req_i     (req_i),
        .busy_i    (busy_i),
        .ack_o     (ack_o),
        .gate_en_o (gate_en_o),
        .state_o   (state_o),
        .wake_cnt_o(wake_cnt_o)
    );

    function automatic void model_reset();
        m_en   = 1'b0;
        m_age  = 0;
        m_idle = 0;
        m_wake = 0;
    endfunction

    function automatic void model_step(input logic [NR-1:0] r, input logic b);
        bit act;
        act = (r != '0) || b;
        if (!m_en) begin
            if (act) begin
                m_en   = 1'b1;
                m_age  = 1;
                m_idle = 0;
                if (m_wake < 65535) m_wake++;
            end
        end else if (m_age <= WK) begin
            m_age++;
        end else if (act) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle > ID) begin
                m_en   = 1'b0;
                m_idle = 0;
            end
        end
    endfunction

    function automatic logic [1:0] m_state();
        if (!m_en)        return 2'd0;
        if (m_age <= WK)  return 2'd1;
        if (m_idle == 0)  return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [22:0] exp_vec(input logic [NR-1:0] r);
        logic [1:0]  s;
        logic [15:0] w;
        s = m_state();
        w = m_wake[15:0];
        return {s, m_en, (s == 2'd2) ? r : {NR{1'b0}}, w};
    endfunction

    function automatic logic [22:0] dut_vec();
        return {state_o, gate_en_o, ack_o, wake_cnt_o};
    endfunction

    // Called at a negedge: apply inputs, advance one rising edge, return at the next negedge.
    task automatic tick(input logic [NR-1:0] r, input logic b);
        req_i  = r;
        busy_i = b;
        @(posedge clk_i);
        model_step(r, b);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        arst_i = 1'b1;
        req_i  = '0;
        busy_i = 1'b0;
        model_reset();
        #2;
        checks++;
        if (dut_vec() !== 23'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), 23'd0);
        end
        req_i = 4'b1111;
        @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (dut_vec() !== {2'd0, 1'b0, 4'b0000, 16'd0}) begin
            errors++;
            $display("FAIL reset_held_with_req: got %h want %h", dut_vec(), 23'd0);
        end
        req_i  = '0;
        arst_i = 1'b0;
    endtask

    task automatic test_wake();
        tick(4'b0001, 1'b0);
        checks++;
        if ({state_o, gate_en_o, ack_o} !== {2'd1, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL wake_c1: got st=%0d en=%b ack=%b want st=1 en=1 ack=0000", state_o, gate_en_o, ack_o);
        end
        tick(4'b0001, 1'b0);
        checks++;
        if ({state_o, gate_en_o, ack_o} !== {2'd1, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL wake_c2: got st=%0d en=%b ack=%b want st=1 en=1 ack=0000", state_o, gate_en_o, ack_o);
        end
        tick(4'b0001, 1'b0);
        checks++;
        if ({state_o, gate_en_o, ack_o, wake_cnt_o} !== {2'd2, 1'b1, 4'b0001, 16'd1}) begin
            errors++;
            $display("FAIL wake_c3: got st=%0d en=%b ack=%b wc=%0d want st=2 en=1 ack=0001 wc=1",
                     state_o, gate_en_o, ack_o, wake_cnt_o);
        end
    endtask

    task automatic test_drain();
        int bad;
        bad = 0;
        tick(4'b0000, 1'b0);
        for (int i = 1; i <= ID; i++) begin
            checks++;
            if (state_o !== 2'd3 || gate_en_o !== 1'b1 || ack_o !== 4'b0000) begin
                errors++;
                $display("FAIL drain_cycle_%0d: got st=%0d en=%b want st=3 en=1", i, state_o, gate_en_o);
            end
            tick(4'b0000, 1'b0);
        end
        checks++;
        if (state_o !== 2'd0 || gate_en_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_off: got st=%0d en=%b want st=0 en=0", state_o, gate_en_o);
        end
    endtask

    task automatic test_rewake();
        for (int i = 0; i < 3; i++) tick(4'b0001, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick(4'b0000, 1'b0);
            checks++;
            if (state_o !== 2'd3 || gate_en_o !== 1'b1) begin
                errors++;
                $display("FAIL rewake_drain_%0d: got st=%0d en=%b want st=3 en=1", i, state_o, gate_en_o);
            end
        end
        tick(4'b0100, 1'b0);
        checks++;
        if ({state_o, gate_en_o, ack_o, wake_cnt_o} !== {2'd2, 1'b1, 4'b0100, 16'd2}) begin
            errors++;
            $display("FAIL rewake_on: got st=%0d en=%b ack=%b wc=%0d want st=2 en=1 ack=0100 wc=2",
                     state_o, gate_en_o, ack_o, wake_cnt_o);
        end
    endtask

    task automatic test_busy();
        for (int i = 0; i < 40; i++) begin
            tick(4'b0000, 1'b1);
            checks++;
            if (state_o !== 2'd2 || ack_o !== 4'b0000 || gate_en_o !== 1'b1) begin
                errors++;
                $display("FAIL busy_hold_%0d: got st=%0d ack=%b want st=2 ack=0000", i, state_o, ack_o);
            end
        end
        tick(4'b0000, 1'b0);
        checks++;
        if (state_o !== 2'd3) begin
            errors++;
            $display("FAIL busy_release: got st=%0d want st=3", state_o);
        end
        for (int i = 0; i < ID; i++) tick(4'b0000, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec(req_i)) begin
            errors++;
            $display("FAIL busy_to_off: got %h want %h", dut_vec(), exp_vec(req_i));
        end
    endtask

    task automatic test_expiry_priority();
        for (int i = 0; i < 3; i++) tick(4'b0010, 1'b0);
        for (int i = 0; i < ID; i++) tick(4'b0000, 1'b0);
        checks++;
        if (state_o !== 2'd3) begin
            errors++;
            $display("FAIL expiry_last_drain: got st=%0d want st=3", state_o);
        end
        tick(4'b0010, 1'b0);
        checks++;
        if ({state_o, gate_en_o, ack_o} !== {2'd2, 1'b1, 4'b0010}) begin
            errors++;
            $display("FAIL expiry_priority: got st=%0d en=%b ack=%b want st=2 en=1 ack=0010",
                     state_o, gate_en_o, ack_o);
        end
    endtask

    task automatic test_async_reset();
        tick(4'b1111, 1'b0);
        checks++;
        if (ack_o !== 4'b1111) begin
            errors++;
            $display("FAIL areset_pre: got ack=%b want 1111", ack_o);
        end
        #2 arst_i = 1'b1;
        #1;
        checks++;
        if ({state_o, gate_en_o, ack_o} !== {2'd0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL areset_async: got st=%0d en=%b ack=%b want st=0 en=0 ack=0000",
                     state_o, gate_en_o, ack_o);
        end
        @(negedge clk_i);
        arst_i = 1'b0;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            tick(4'b1111, 1'b0);
            checks++;
            if (ack_o !== ((i == 3) ? 4'b1111 : 4'b0000) || gate_en_o !== 1'b1 || wake_cnt_o !== 16'd1) begin
                errors++;
                $display("FAIL areset_rewake_%0d: got ack=%b en=%b wc=%0d", i, ack_o, gate_en_o, wake_cnt_o);
            end
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] r;
        logic          b;
        int            len;
        bit            active;
        for (int burst = 0; burst < 200; burst++) begin
            len    = $urandom_range(1, 24);
            active = ($urandom % 3) != 0 ? 1'b0 : 1'b1;
            for (int c = 0; c < len; c++) begin
                r = active ? NR'($urandom) : '0;
                b = active ? 1'($urandom) : 1'b0;
                tick(r, b);
                checks++;
                if (dut_vec() !== exp_vec(r)) begin
                    errors++;
                    $display("FAIL random_b%0d_c%0d: got %h want %h", burst, c, dut_vec(), exp_vec(r));
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_w [3];
        int          guard;
        exp_w = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
        guard = 0;
        while (m_state() != 2'd0 && guard < 60) begin
            tick(4'b0000, 1'b0);
            guard++;
        end
        force dut.wake_cnt_q = 16'hFFFD;
        #1 release dut.wake_cnt_q;
        m_wake = 65533;
        for (int k = 0; k < 3; k++) begin
            tick(4'b0001, 1'b0);
            checks++;
            if (wake_cnt_o !== exp_w[k] || state_o !== 2'd1) begin
                errors++;
                $display("FAIL saturate_%0d: got wc=%h st=%0d want wc=%h st=1", k, wake_cnt_o, state_o, exp_w[k]);
            end
            guard = 0;
            while (m_state() != 2'd0 && guard < 60) begin
                tick(4'b0000, 1'b0);
                guard++;
            end
            checks++;
            if (dut_vec() !== exp_vec(4'b0000)) begin
                errors++;
                $display("FAIL saturate_off_%0d: got %h want %h", k, dut_vec(), exp_vec(4'b0000));
            end
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk_i);
        test_wake();
        test_drain();
        test_rewake();
        test_busy();
        test_expiry_priority();
        test_async_reset();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
